inreg_bank_hs: RTL

- Parametrised input register bank that feeds the perceptron (DSP) array.
- Generalises the fixed 40-lane input shift register:
  - N and B are parameters.
  - Four load modes: shift, addressed, broadcast, hold.
  - valid/ready input handshake.
  - Frame-completion tracking, with frame_valid/frame_ack back-pressure toward the DSP array.
- Sits between the input stream/controller and the N perceptron operand inputs.

---
 rtl/inreg_bank_hs.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/inreg_bank_hs.sv
// inreg_bank_hs: parametrised input register bank feeding the perceptron array.
//
// Lanes are loaded through a valid/ready beat interface in one of four modes:
//   00 shift      : lane0 <= in_data, lane i <= lane i-1; frame after N beats
//   01 addressed  : lane[in_addr] <= in_data; frame once every lane is written
//   10 broadcast  : all lanes <= in_data; frame on that same beat
//   11 hold       : no beats accepted, state kept
// A completed frame raises frame_valid until frame_ack is sampled.
//
// Optional feature (macro INREG_DOUBLE_BUF_EN): a shadow bank drives out, so the
// next frame may be loaded while the previous one is still being consumed.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   mode        load mode (see above)
//   in_data     lane value of an input beat
//   in_addr     target lane for addressed mode
//   in_valid    beat offered
//   in_ready    bank can accept a beat
//   clr         synchronous clear of lanes, counters and written mask
//   out         lane i on out[(i+1)*B-1:i*B], registered
//   frame_valid complete frame present on out
//   frame_ack   frame consumed by the DSP array
//   addr_err    one-cycle pulse: addressed beat with in_addr >= N dropped
//   fill_cnt    lanes/beats filled in the current frame
module inreg_bank_hs #(
  parameter int unsigned B  = 8,
  parameter int unsigned N  = 40,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [B-1:0]  in_data,
  input  logic [AW-1:0] in_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          clr,
  output logic [N*B-1:0] out,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic          addr_err,
  output logic [AW:0]   fill_cnt
);

  typedef enum logic [1:0] {
    ModeShift = 2'b00,
    ModeAddr  = 2'b01,
    ModeBcast = 2'b10,
    ModeHold  = 2'b11
  } mode_e;

  mode_e mode_in, mode_q;

  logic [N-1:0][B-1:0] lanes_q, lanes_d;
  logic [N-1:0]        mask_q, mask_d, mask_eff, addr_hot;
  logic [AW:0]         fill_q, fill_d, fill_eff;
  logic                fv_q, fv_d;
  logic                err_q, err_d;
  logic                mode_chg, addr_ok, completes, accept;

`ifdef INREG_DOUBLE_BUF_EN
  logic [N-1:0][B-1:0] shadow_q, shadow_d;
`endif

  assign mode_in  = mode_e'(mode);
  // A mode change restarts the frame count; lanes are untouched.
  assign mode_chg = (mode_in != mode_q);
  assign fill_eff = mode_chg ? '0 : fill_q;
  assign mask_eff = mode_chg ? '0 : mask_q;

  // One-hot lane decode; all-zero when in_addr is outside 0..N-1.
  always_comb begin
    addr_hot = '0;
    for (int i = 0; i < N; i++) begin
      if (in_addr == AW'(i)) addr_hot[i] = 1'b1;
    end
  end
  assign addr_ok = |addr_hot;

  // Whether a beat accepted this cycle would complete a frame.
  always_comb begin
    completes = 1'b0;
    unique case (mode_in)
      ModeShift: completes = (fill_eff == (AW+1)'(N - 1));
      ModeAddr:  completes = addr_ok && (&(mask_eff | addr_hot));
      ModeBcast: completes = 1'b1;
      ModeHold:  completes = 1'b0;
    endcase
  end

`ifdef INREG_DOUBLE_BUF_EN
  // Only a second completion has to wait; an ack in the same cycle frees the shadow.
  assign in_ready = !clr && (mode_in != ModeHold) && !(fv_q && !frame_ack && completes);
`else
  assign in_ready = !clr && (mode_in != ModeHold) && !fv_q;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    lanes_d = lanes_q;
    mask_d  = mask_eff;
    fill_d  = fill_eff;
    fv_d    = fv_q && !frame_ack;
    err_d   = 1'b0;
`ifdef INREG_DOUBLE_BUF_EN
    shadow_d = shadow_q;
`endif

    if (accept) begin
      unique case (mode_in)
        ModeShift: begin
          lanes_d = {lanes_q[N-2:0], in_data};
          fill_d  = fill_eff + (AW+1)'(1);
        end
        ModeAddr: begin
          if (addr_ok) begin
            for (int i = 0; i < N; i++) begin
              if (addr_hot[i]) lanes_d[i] = in_data;
            end
            mask_d = mask_eff | addr_hot;
            // A rewrite of an already-written lane does not advance the count.
            if (!(|(mask_eff & addr_hot))) fill_d = fill_eff + (AW+1)'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        ModeBcast: lanes_d = {N{in_data}};
        ModeHold:  ;
      endcase

      // A completion on the ack edge wins: the new frame is what is now valid.
      if (completes) begin
        fv_d   = 1'b1;
        fill_d = '0;
        mask_d = '0;
`ifdef INREG_DOUBLE_BUF_EN
        shadow_d = lanes_d;
`endif
      end
    end

    if (clr) begin
      lanes_d = '0;
      mask_d  = '0;
      fill_d  = '0;
      fv_d    = 1'b0;
      err_d   = 1'b0;
`ifdef INREG_DOUBLE_BUF_EN
      shadow_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= ModeShift;
      lanes_q <= '0;
      mask_q  <= '0;
      fill_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_in;
      lanes_q <= lanes_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

`ifdef INREG_DOUBLE_BUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) shadow_q <= '0;
    else      shadow_q <= shadow_d;
  end
  assign out = shadow_q;
`else
  assign out = lanes_q;
`endif

  assign frame_valid = fv_q;
  assign addr_err    = err_q;
  assign fill_cnt    = fill_q;

endmodule
